// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_ctrl_pkg : opcodes, FSM state encoding and sizing helper for sys_ctrl  |
// | Rev 2.0                                                                    |
// +----------------------------------------------------------------------------+
package sys_ctrl_pkg;

  localparam logic [7:0] c_OP_WR   = 8'hAA;
  localparam logic [7:0] c_OP_RD   = 8'hBB;
  localparam logic [7:0] c_OP_ALU  = 8'hCC;
  localparam logic [7:0] c_OP_ALUF = 8'hDD;
  localparam logic [7:0] c_OP_BRD  = 8'hEE;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ADDR = 4'd1,
    GET_DATA = 4'd2,
    GET_OPA  = 4'd3,
    GET_OPB  = 4'd4,
    GET_FUN  = 4'd5,
    GET_CNT  = 4'd6,
    RD_REQ   = 4'd7,
    RD_WAIT  = 4'd8,
    ALU_RUN  = 4'd9,
    PUSH     = 4'd10,
    ERR      = 4'd11
  } state_t;

  // Bits needed to hold a word count in 0..n.
  function automatic int res_idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_resp_push.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_ctrl_resp_push : response word queue draining into the TX FIFO,        |
// | least-significant word first, stalling while the FIFO is full.             |
// | Rev 2.0                                                                    |
// +----------------------------------------------------------------------------+
module sys_ctrl_resp_push
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WORDS  = 2,
  parameter int CNT_W      = res_idx_w(RES_WORDS)
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic                            i_load,
  input  logic [RES_WORDS*DATA_WIDTH-1:0] i_words,
  input  logic [CNT_W-1:0]                i_nwords,
  input  logic                            i_FIFO_FULL,
  output logic [DATA_WIDTH-1:0]           o_FIFO_DATA,
  output logic                            o_WR_INC,
  output logic                            o_done
);

  logic [RES_WORDS*DATA_WIDTH-1:0] r_words;
  logic [CNT_W-1:0]                r_left;
  logic                            r_busy;
  logic                            w_push;

  assign w_push      = r_busy && !i_FIFO_FULL;
  assign o_WR_INC    = w_push;
  assign o_FIFO_DATA = r_words[DATA_WIDTH-1:0];
  // Asserted in the cycle the last queued word is accepted by the FIFO.
  assign o_done      = w_push && (r_left == CNT_W'(1));

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_words <= '0;
      r_left  <= '0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_words <= i_words;
      r_left  <= i_nwords;
      r_busy  <= (i_nwords != '0);
    end else if (w_push) begin
      r_words <= r_words >> DATA_WIDTH;
      r_left  <= r_left - 1'b1;
      if (r_left == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sys_ctrl_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_ctrl_v2 : REF_CLK-domain system controller decoding UART command       |
// | frames into register-file, ALU and TX FIFO transactions.                   |
// | Rev 2.0                                                                    |
// +----------------------------------------------------------------------------+
module sys_ctrl_v2
  import sys_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    ALU_FUN_WIDTH = 4,
  parameter int                    RES_WORDS     = 2,
  parameter int                    TIMEOUT_CYC   = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE      = 8'hFF,
  parameter bit                    RESP_ON_ERR   = 1'b1
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic [DATA_WIDTH-1:0]           i_RX_P_DATA,
  input  logic                            i_RX_D_VLD,
  input  logic [RES_WORDS*DATA_WIDTH-1:0] i_ALU_OUT,
  input  logic                            i_OUT_Valid,
  input  logic [DATA_WIDTH-1:0]           i_RdData,
  input  logic                            i_RdData_Valid,
  input  logic                            i_FIFO_FULL,
  output logic [ALU_FUN_WIDTH-1:0]        o_ALU_FUN,
  output logic                            o_ALU_EN,
  output logic                            o_CLK_EN,
  output logic [ADDR_WIDTH-1:0]           o_Address,
  output logic                            o_WrEn,
  output logic [DATA_WIDTH-1:0]           o_WrData,
  output logic                            o_RdEn,
  output logic [DATA_WIDTH-1:0]           o_FIFO_DATA,
  output logic                            o_WR_INC,
  output logic                            o_clk_div_en,
  output logic                            o_frame_err,
  output logic                            o_rx_overrun
);

  localparam int CNT_W = res_idx_w(RES_WORDS);
  localparam int TO_W  = 16;
  localparam logic [DATA_WIDTH-1:0] c_WR   = DATA_WIDTH'(c_OP_WR);
  localparam logic [DATA_WIDTH-1:0] c_RD   = DATA_WIDTH'(c_OP_RD);
  localparam logic [DATA_WIDTH-1:0] c_ALU  = DATA_WIDTH'(c_OP_ALU);
  localparam logic [DATA_WIDTH-1:0] c_ALUF = DATA_WIDTH'(c_OP_ALUF);
  localparam logic [DATA_WIDTH-1:0] c_BRD  = DATA_WIDTH'(c_OP_BRD);

  state_t                          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]           r_op;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [DATA_WIDTH-1:0]           r_wr_data;
  logic                            r_wr_en;
  logic [ALU_FUN_WIDTH-1:0]        r_fun;
  logic [DATA_WIDTH-1:0]           r_cnt;
  logic [TO_W-1:0]                 r_to;
  logic                            r_ovr;
  logic                            r_clk_div_en;

  logic                            w_rx_state, w_get_state, w_counting, w_busy_state;
  logic                            w_accept, w_to_hit, w_push_done;
  logic                            w_load;
  logic [RES_WORDS*DATA_WIDTH-1:0] w_load_words;
  logic [CNT_W-1:0]                w_load_n;

  assign w_get_state  = r_state inside {GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, GET_CNT};
  assign w_rx_state   = w_get_state || (r_state == IDLE);
  assign w_counting   = w_get_state || (r_state == RD_WAIT);
  assign w_busy_state = r_state inside {RD_REQ, RD_WAIT, ALU_RUN, PUSH, ERR};
  assign w_accept     = i_RX_D_VLD && w_rx_state;
  // An accepted byte or arriving read data beats the terminal count.
  assign w_to_hit     = w_counting && !w_accept && !((r_state == RD_WAIT) && i_RdData_Valid)
                        && (r_to == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_words = '0;
    w_load_n     = '0;
    case (r_state)
      IDLE: begin
        if (i_RX_D_VLD) begin
          if ((i_RX_P_DATA == c_WR) || (i_RX_P_DATA == c_RD) || (i_RX_P_DATA == c_BRD)) begin
            w_state_nxt = GET_ADDR;
          end else if (i_RX_P_DATA == c_ALU) begin
            w_state_nxt = GET_OPA;
          end else if (i_RX_P_DATA == c_ALUF) begin
            w_state_nxt = GET_FUN;
          end else begin
            w_state_nxt = ERR;
          end
        end
      end
      GET_ADDR: begin
        if (i_RX_D_VLD) begin
          if (r_op == c_WR) begin
            w_state_nxt = GET_DATA;
          end else if (r_op == c_BRD) begin
            w_state_nxt = GET_CNT;
          end else begin
            w_state_nxt = RD_REQ;
          end
        end
      end
      GET_DATA: if (i_RX_D_VLD) w_state_nxt = IDLE;
      GET_OPA:  if (i_RX_D_VLD) w_state_nxt = GET_OPB;
      GET_OPB:  if (i_RX_D_VLD) w_state_nxt = GET_FUN;
      GET_FUN:  if (i_RX_D_VLD) w_state_nxt = ALU_RUN;
      GET_CNT: begin
        if (i_RX_D_VLD) begin
          w_state_nxt = (i_RX_P_DATA == '0) ? ERR : RD_REQ;
        end
      end
      RD_REQ: w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (i_RdData_Valid) begin
          w_load                       = 1'b1;
          w_load_words[DATA_WIDTH-1:0] = i_RdData;
          w_load_n                     = CNT_W'(1);
          w_state_nxt                  = PUSH;
        end
      end
      ALU_RUN: begin
        if (i_OUT_Valid) begin
          w_load       = 1'b1;
          w_load_words = i_ALU_OUT;
          w_load_n     = CNT_W'(RES_WORDS);
          w_state_nxt  = PUSH;
        end
      end
      PUSH: begin
        if (w_push_done) begin
          w_state_nxt = (r_cnt > DATA_WIDTH'(1)) ? RD_REQ : IDLE;
        end
      end
      ERR: begin
        if (RESP_ON_ERR) begin
          w_load                       = 1'b1;
          w_load_words[DATA_WIDTH-1:0] = ERR_CODE;
          w_load_n                     = CNT_W'(1);
          w_state_nxt                  = PUSH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_to_hit) begin
      w_state_nxt = ERR;
    end
  end

  // Frame fields; r_cnt holds the reads still owed, including the one in flight.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_op      <= '0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_fun     <= '0;
      r_cnt     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            r_op  <= i_RX_P_DATA;
            r_cnt <= '0;
          end
          GET_ADDR: begin
            r_addr <= i_RX_P_DATA[ADDR_WIDTH-1:0];
            if (r_op == c_RD) r_cnt <= DATA_WIDTH'(1);
          end
          GET_DATA: begin
            r_wr_data <= i_RX_P_DATA;
            r_wr_en   <= 1'b1;
          end
          GET_OPA: begin
            r_addr    <= '0;
            r_wr_data <= i_RX_P_DATA;
            r_wr_en   <= 1'b1;
          end
          GET_OPB: begin
            r_addr    <= ADDR_WIDTH'(1);
            r_wr_data <= i_RX_P_DATA;
            r_wr_en   <= 1'b1;
          end
          GET_FUN: r_fun <= i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
          GET_CNT: r_cnt <= i_RX_P_DATA;
          default: ;
        endcase
      end
      if ((r_state == PUSH) && w_push_done && (r_cnt > DATA_WIDTH'(1))) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (r_state == ERR) begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_to         <= '0;
      r_ovr        <= 1'b0;
      r_clk_div_en <= 1'b0;
    end else begin
      r_clk_div_en <= 1'b1;
      r_ovr        <= i_RX_D_VLD && w_busy_state;
      if (!w_counting || w_accept) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  sys_ctrl_resp_push #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WORDS  (RES_WORDS),
    .CNT_W      (CNT_W)
  ) u_resp_push (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_load      (w_load),
    .i_words     (w_load_words),
    .i_nwords    (w_load_n),
    .i_FIFO_FULL (i_FIFO_FULL),
    .o_FIFO_DATA (o_FIFO_DATA),
    .o_WR_INC    (o_WR_INC),
    .o_done      (w_push_done)
  );

  // ALU enables decode straight from the state so reset removes them without a clock.
  assign o_CLK_EN     = (r_state == ALU_RUN);
  assign o_ALU_EN     = (r_state == ALU_RUN);
  assign o_ALU_FUN    = r_fun;
  assign o_RdEn       = (r_state == RD_REQ);
  assign o_frame_err  = (r_state == ERR);
  assign o_Address    = r_addr;
  assign o_WrEn       = r_wr_en;
  assign o_WrData     = r_wr_data;
  assign o_rx_overrun = r_ovr;
  assign o_clk_div_en = r_clk_div_en;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sys_ctrl_v2 : directed bench for sys_ctrl_v2 with a TX push scoreboard  |
// | Rev 2.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sys_ctrl_v2;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AFW = 4;
  localparam int RW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [DW-1:0]  rx_data = '0;
  logic           rx_vld = 1'b0;
  logic [RW*DW-1:0] alu_out = '0;
  logic           alu_vld = 1'b0;
  logic [DW-1:0]  rd_data = '0;
  logic           rd_vld = 1'b0;
  logic           fifo_full = 1'b0;

  logic [AFW-1:0] o_ALU_FUN;
  logic           o_ALU_EN, o_CLK_EN, o_WrEn, o_RdEn, o_WR_INC;
  logic           o_clk_div_en, o_frame_err, o_rx_overrun;
  logic [AW-1:0]  o_Address;
  logic [DW-1:0]  o_WrData, o_FIFO_DATA;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mem[0:15];

  sys_ctrl_v2 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FUN_WIDTH(AFW), .RES_WORDS(RW),
    .TIMEOUT_CYC(32), .ERR_CODE(8'hFF), .RESP_ON_ERR(1'b1)
  ) dut (
    .i_CLK(clk), .i_RST(rst_n),
    .i_RX_P_DATA(rx_data), .i_RX_D_VLD(rx_vld),
    .i_ALU_OUT(alu_out), .i_OUT_Valid(alu_vld),
    .i_RdData(rd_data), .i_RdData_Valid(rd_vld),
    .i_FIFO_FULL(fifo_full),
    .o_ALU_FUN(o_ALU_FUN), .o_ALU_EN(o_ALU_EN), .o_CLK_EN(o_CLK_EN),
    .o_Address(o_Address), .o_WrEn(o_WrEn), .o_WrData(o_WrData), .o_RdEn(o_RdEn),
    .o_FIFO_DATA(o_FIFO_DATA), .o_WR_INC(o_WR_INC), .o_clk_div_en(o_clk_div_en),
    .o_frame_err(o_frame_err), .o_rx_overrun(o_rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    cycles(3);
    check("drain_scoreboard_empty", sb.size(), 0);
  endtask

  // Pushes, error and overrun pulses observed just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (o_frame_err)  n_ferr++;
      if (o_rx_overrun) n_ovr++;
      if (o_WR_INC) begin
        n_push++;
        check("push_while_full", fifo_full, 0);
        check("push_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) check("push_data", o_FIFO_DATA, sb.pop_front());
      end
    end
  end

  // Register-file model: read data valid one cycle after the read strobe.
  initial begin
    logic          pend;
    logic [AW-1:0] pa;
    pend = 1'b0;
    pa   = '0;
    forever begin
      @(negedge clk);
      rd_vld = 1'b0;
      if (pend) begin
        rd_data = mem[pa];
        rd_vld  = 1'b1;
        pend    = 1'b0;
      end
      if (o_RdEn) begin
        pend = 1'b1;
        pa   = o_Address;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, o0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[5]  = 8'h3C;
    mem[14] = 8'hA1;
    mem[15] = 8'hB2;
    mem[0]  = 8'hC3;

    // Reset
    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_clk_div_en", o_clk_div_en, 0);
    check("rst_wr_inc", o_WR_INC, 0);
    check("rst_wren", o_WrEn, 0);
    check("rst_rden", o_RdEn, 0);
    check("rst_clk_en", o_CLK_EN, 0);
    check("rst_fifo_data", o_FIFO_DATA, 0);
    check("rst_address", o_Address, 0);
    rst_n = 1'b1;
    #1 check("clk_div_en_before_edge", o_clk_div_en, 0);
    cycles(1);
    check("clk_div_en_after_edge", o_clk_div_en, 1);

    // Register write AA 05 3C
    p0 = n_push;
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_wren", o_WrEn, 1);
    check("wr_addr", o_Address, 5);
    check("wr_data", o_WrData, 8'h3C);
    cycles(1);
    check("wr_wren_single", o_WrEn, 0);
    cycles(3);
    check("wr_no_push", n_push, p0);

    // Register read BB 05 against a full FIFO
    fifo_full = 1'b1;
    sb.push_back(8'h3C);
    p0 = n_push;
    send(8'hBB); send(8'h05);
    cycles(10);
    check("rd_held_while_full", n_push, p0);
    check("rd_data_stable", o_FIFO_DATA, 8'h3C);
    fifo_full = 1'b0;
    drain(20);
    check("rd_one_push", n_push, p0 + 1);

    // ALU with operands CC 12 34 00
    sb.push_back(8'h46);
    sb.push_back(8'h00);
    p0 = n_push;
    send(8'hCC);
    send(8'h12);
    check("opa_wren", o_WrEn, 1);
    check("opa_addr", o_Address, 0);
    check("opa_data", o_WrData, 8'h12);
    send(8'h34);
    check("opb_wren", o_WrEn, 1);
    check("opb_addr", o_Address, 1);
    check("opb_data", o_WrData, 8'h34);
    send(8'h00);
    cycles(3);
    check("alu_clk_en", o_CLK_EN, 1);
    check("alu_en", o_ALU_EN, 1);
    check("alu_fun0", o_ALU_FUN, 0);
    alu_out = 16'h0046;
    alu_vld = 1'b1;
    #1 check("alu_clk_en_valid_cycle", o_CLK_EN, 1);
    @(negedge clk);
    alu_vld = 1'b0;
    #1 check("alu_clk_en_dropped", o_CLK_EN, 0);
    check("alu_en_dropped", o_ALU_EN, 0);
    drain(20);
    check("alu_two_pushes", n_push, p0 + 2);

    // Burst read with address wrap EE 0E 03
    sb.push_back(8'hA1);
    sb.push_back(8'hB2);
    sb.push_back(8'hC3);
    p0 = n_push;
    send(8'hEE); send(8'h0E); send(8'h03);
    drain(60);
    check("burst_three_pushes", n_push, p0 + 3);

    // Burst of zero words is an error
    f0 = n_ferr;
    sb.push_back(8'hFF);
    send(8'hEE); send(8'h02); send(8'h00);
    drain(20);
    check("burst_n0_frame_err", n_ferr, f0 + 1);

    // Inter-byte timeout then a clean write
    f0 = n_ferr;
    sb.push_back(8'hFF);
    send(8'hAA); send(8'h05);
    cycles(20);
    check("timeout_not_early", n_ferr, f0);
    cycles(20);
    check("timeout_frame_err", n_ferr, f0 + 1);
    drain(20);
    send(8'hAA); send(8'h06); send(8'h11);
    check("post_to_wren", o_WrEn, 1);
    check("post_to_addr", o_Address, 6);
    check("post_to_data", o_WrData, 8'h11);

    // Bad opcode, then a byte arriving while the error word waits in PUSH
    f0 = n_ferr;
    o0 = n_ovr;
    fifo_full = 1'b1;
    sb.push_back(8'hFF);
    send(8'h55);
    send(8'h77);
    cycles(3);
    check("bad_op_frame_err", n_ferr, f0 + 1);
    check("overrun_pulse", n_ovr, o0 + 1);
    fifo_full = 1'b0;
    drain(20);
    send(8'hAA); send(8'h07); send(8'h22);
    check("post_ovr_wren", o_WrEn, 1);
    check("post_ovr_addr", o_Address, 7);
    check("post_ovr_data", o_WrData, 8'h22);

    // Reset while the ALU runs
    send(8'hDD); send(8'h03);
    check("dd_clk_en", o_CLK_EN, 1);
    check("dd_fun", o_ALU_FUN, 3);
    #2 rst_n = 1'b0;
    #1 check("async_clk_en_drop", o_CLK_EN, 0);
    check("async_alu_en_drop", o_ALU_EN, 0);
    check("async_fun_clear", o_ALU_FUN, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("final_clk_div_en", o_clk_div_en, 1);
    check("final_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
